// File: rtl/wb_stage_rf.sv
// wb_stage_rf: write-back stage with an 8x16 register file, same-cycle read bypass and R7 redirect.
// Optional retired-instruction counter is compiled in when WB_RETIRE_CNT_EN is defined.
module wb_stage_rf (
  input  logic        clk,
  input  logic        clr,
  input  logic [15:0] pc_wb_16,
  input  logic [15:0] instr_wb_16,
  input  logic [7:0]  cw_wb_8,
  input  logic [15:0] in_wb_16,
  input  logic [2:0]  k_wb_3,
  input  logic [2:0]  dest_wb_3,
  input  logic [2:0]  ra_addr_3,
  input  logic [2:0]  rb_addr_3,
  output logic [15:0] ra_data_16,
  output logic [15:0] rb_data_16,
  output logic        wb_we,
  output logic [2:0]  wb_addr_3,
  output logic [15:0] wb_data_16,
  output logic        redirect_valid,
  output logic [15:0] redirect_pc_16,
  output logic [15:0] retired_cnt_16
);

  localparam int         NREGS  = 8;
  localparam int         DW     = 16;
  localparam logic [2:0] PC_REG = 3'd7;

  localparam logic [1:0] SEL_IN   = 2'b00;
  localparam logic [1:0] SEL_PC1  = 2'b01;
  localparam logic [1:0] SEL_IMM  = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  // Handshake: cw_wb_8[0] (valid) qualifies the WB slot for one cycle; there is no ready,
  // the stage accepts every cycle, and a re-presented write simply rewrites the same value.
  logic          rf_we;
  logic          use_k;
  logic          valid;
  logic [1:0]    wb_sel;

  logic [DW-1:0] rf_q [NREGS];
  logic [DW-1:0] rf_d [NREGS];
  logic          redirect_valid_q, redirect_valid_d;
  logic [DW-1:0] redirect_pc_q, redirect_pc_d;

  logic          unused_bits;
  assign unused_bits = ^{cw_wb_8[3:1], instr_wb_16[15:9]};

  always_comb begin
    rf_we     = cw_wb_8[7];
    wb_sel    = cw_wb_8[6:5];
    use_k     = cw_wb_8[4];
    valid     = cw_wb_8[0];

    wb_addr_3 = use_k ? k_wb_3 : dest_wb_3;
    wb_we     = valid & rf_we & (wb_sel != SEL_NONE);

    case (wb_sel)
      SEL_IN:  wb_data_16 = in_wb_16;
      SEL_PC1: wb_data_16 = pc_wb_16 + 16'd1;
      SEL_IMM: wb_data_16 = {instr_wb_16[8:0], 7'b0};
      default: wb_data_16 = in_wb_16;
    endcase
  end

  // Bypass the in-flight write so decode sees it in the same cycle it is committed.
  always_comb begin
    ra_data_16 = (wb_we && (ra_addr_3 == wb_addr_3)) ? wb_data_16 : rf_q[ra_addr_3];
    rb_data_16 = (wb_we && (rb_addr_3 == wb_addr_3)) ? wb_data_16 : rf_q[rb_addr_3];
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      rf_d[i] = rf_q[i];
    end
    if (wb_we) begin
      rf_d[wb_addr_3] = wb_data_16;
    end

    redirect_valid_d = wb_we && (wb_addr_3 == PC_REG);
    redirect_pc_d    = redirect_valid_d ? wb_data_16 : redirect_pc_q;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= rf_d[i];
      end
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc_16 = redirect_pc_q;

`ifdef WB_RETIRE_CNT_EN
  logic [DW-1:0] retired_cnt_q, retired_cnt_d;

  // Counts valid slots regardless of whether they write; wraps naturally.
  always_comb begin
    retired_cnt_d = retired_cnt_q + {{(DW-1){1'b0}}, valid};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      retired_cnt_q <= '0;
    end else begin
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign retired_cnt_16 = retired_cnt_q;
`else
  assign retired_cnt_16 = '0;
`endif

endmodule

// File: tb/tb_wb_stage_rf.sv
// Testbench for wb_stage_rf: directed scenarios plus randomized traffic against a behavioural model.
module tb_wb_stage_rf;

  logic        clk;
  logic        clr;
  logic [15:0] pc_wb_16;
  logic [15:0] instr_wb_16;
  logic [7:0]  cw_wb_8;
  logic [15:0] in_wb_16;
  logic [2:0]  k_wb_3;
  logic [2:0]  dest_wb_3;
  logic [2:0]  ra_addr_3;
  logic [2:0]  rb_addr_3;
  logic [15:0] ra_data_16;
  logic [15:0] rb_data_16;
  logic        wb_we;
  logic [2:0]  wb_addr_3;
  logic [15:0] wb_data_16;
  logic        redirect_valid;
  logic [15:0] redirect_pc_16;
  logic [15:0] retired_cnt_16;

  wb_stage_rf dut (
    .clk            (clk),
    .clr            (clr),
    .pc_wb_16       (pc_wb_16),
    .instr_wb_16    (instr_wb_16),
    .cw_wb_8        (cw_wb_8),
    .in_wb_16       (in_wb_16),
    .k_wb_3         (k_wb_3),
    .dest_wb_3      (dest_wb_3),
    .ra_addr_3      (ra_addr_3),
    .rb_addr_3      (rb_addr_3),
    .ra_data_16     (ra_data_16),
    .rb_data_16     (rb_data_16),
    .wb_we          (wb_we),
    .wb_addr_3      (wb_addr_3),
    .wb_data_16     (wb_data_16),
    .redirect_valid (redirect_valid),
    .redirect_pc_16 (redirect_pc_16),
    .retired_cnt_16 (retired_cnt_16)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model / scoreboard ----------------
  int          total;
  int          bad;
  logic [15:0] model_rf [8];
  logic        model_redirect_valid;
  logic [15:0] model_redirect_pc;
  logic [15:0] model_cnt;
  logic [15:0] exp_q [$];

  function automatic logic model_writes(logic [7:0] cw);
    return cw[0] && cw[7] && (cw[6:5] != 2'd3);
  endfunction

  function automatic logic [2:0] model_target(logic [7:0] cw, logic [2:0] k, logic [2:0] dest);
    return cw[4] ? k : dest;
  endfunction

  function automatic logic [15:0] model_value(logic [7:0] cw, logic [15:0] in, logic [15:0] pc,
                                              logic [15:0] instr);
    logic [16:0] next_pc;
    case (cw[6:5])
      2'd0:    return in;
      2'd1: begin
        next_pc = {1'b0, pc} + 17'd1;
        return next_pc[15:0];
      end
      2'd2:    return (instr & 16'h01FF) << 7;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] model_read(logic [2:0] addr);
    if (model_writes(cw_wb_8) && addr == model_target(cw_wb_8, k_wb_3, dest_wb_3))
      return model_value(cw_wb_8, in_wb_16, pc_wb_16, instr_wb_16);
    return model_rf[addr];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [7:0] cw, input logic [2:0] dest, input logic [2:0] k,
                       input logic [15:0] in, input logic [15:0] pc, input logic [15:0] instr);
    cw_wb_8     = cw;
    dest_wb_3   = dest;
    k_wb_3      = k;
    in_wb_16    = in;
    pc_wb_16    = pc;
    instr_wb_16 = instr;
  endtask

  // Advance one clock, update the model from the spec rules, and check registered outputs.
  task automatic tick();
    logic        w;
    logic [2:0]  a;
    logic [15:0] v;
    logic [15:0] got_pc;
    w = model_writes(cw_wb_8);
    a = model_target(cw_wb_8, k_wb_3, dest_wb_3);
    v = model_value(cw_wb_8, in_wb_16, pc_wb_16, instr_wb_16);
    if (clr) begin
      for (int i = 0; i < 8; i++) model_rf[i] = 16'h0000;
      model_redirect_valid = 1'b0;
      model_redirect_pc    = 16'h0000;
      model_cnt            = 16'h0000;
      exp_q.delete();
    end else begin
      if (w) model_rf[a] = v;
      model_redirect_valid = w && (a == 3'd7);
      if (model_redirect_valid) begin
        model_redirect_pc = v;
        exp_q.push_back(v);
      end
`ifdef WB_RETIRE_CNT_EN
      if (cw_wb_8[0]) model_cnt = model_cnt + 16'd1;
`endif
    end
    @(posedge clk);
    #1;
    total++;
    if (redirect_valid !== model_redirect_valid) begin
      bad++;
      $display("FAIL redirect_valid: got %b want %b at %0t", redirect_valid, model_redirect_valid, $time);
    end
    if (model_redirect_valid && exp_q.size() > 0) got_pc = exp_q.pop_front();
    else got_pc = model_redirect_pc;
    total++;
    if (redirect_pc_16 !== got_pc) begin
      bad++;
      $display("FAIL redirect_pc: got %h want %h at %0t", redirect_pc_16, got_pc, $time);
    end
    total++;
    if (retired_cnt_16 !== model_cnt) begin
      bad++;
      $display("FAIL retired_cnt: got %h want %h at %0t", retired_cnt_16, model_cnt, $time);
    end
  endtask

  // Check the combinational write strobe/address/data and both read ports for current inputs.
  task automatic check_comb(input string name);
    logic [15:0] e_ra, e_rb;
    #1;
    e_ra = model_read(ra_addr_3);
    e_rb = model_read(rb_addr_3);
    total++;
    if (wb_we !== model_writes(cw_wb_8)) begin
      bad++;
      $display("FAIL %s wb_we: got %b want %b", name, wb_we, model_writes(cw_wb_8));
    end
    total++;
    if (wb_addr_3 !== model_target(cw_wb_8, k_wb_3, dest_wb_3)) begin
      bad++;
      $display("FAIL %s wb_addr: got %0d want %0d", name, wb_addr_3,
               model_target(cw_wb_8, k_wb_3, dest_wb_3));
    end
    if (cw_wb_8[6:5] != 2'd3) begin
      total++;
      if (wb_data_16 !== model_value(cw_wb_8, in_wb_16, pc_wb_16, instr_wb_16)) begin
        bad++;
        $display("FAIL %s wb_data: got %h want %h", name, wb_data_16,
                 model_value(cw_wb_8, in_wb_16, pc_wb_16, instr_wb_16));
      end
    end
    total++;
    if (ra_data_16 !== e_ra) begin
      bad++;
      $display("FAIL %s ra_data[%0d]: got %h want %h", name, ra_addr_3, ra_data_16, e_ra);
    end
    total++;
    if (rb_data_16 !== e_rb) begin
      bad++;
      $display("FAIL %s rb_data[%0d]: got %h want %h", name, rb_addr_3, rb_data_16, e_rb);
    end
  endtask

  // Sweep every register through both ports with a bubble presented (no bypass possible).
  task automatic check_all_regs(input string name);
    cw_wb_8 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      ra_addr_3 = 3'(i);
      rb_addr_3 = 3'(7 - i);
      check_comb(name);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(8'h81, 3'd7, 3'd0, 16'h5555, 16'h0, 16'h0);
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    drive(8'h00, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
    check_all_regs("reset");
    total++;
    if (redirect_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset redirect_valid: got %b want 0", redirect_valid);
    end
  endtask

  task automatic test_bypass();
    drive(8'h81, 3'd3, 3'd0, 16'hABCD, 16'h0, 16'h0);
    ra_addr_3 = 3'd3;
    rb_addr_3 = 3'd3;
    check_comb("bypass_same_cycle");
    total++;
    if (ra_data_16 !== 16'hABCD) begin
      bad++;
      $display("FAIL bypass_const: got %h want abcd", ra_data_16);
    end
    tick();
    drive(8'h00, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
    check_comb("bypass_stored");
    total++;
    if (ra_data_16 !== 16'hABCD) begin
      bad++;
      $display("FAIL stored_const: got %h want abcd", ra_data_16);
    end
  endtask

  task automatic test_wb_sel();
    drive(8'hC1, 3'd1, 3'd0, 16'h0, 16'h0, 16'h01FF);
    check_comb("sel_imm");
    tick();
    drive(8'hA1, 3'd2, 3'd0, 16'h0, 16'hFFFF, 16'h0);
    check_comb("sel_pc_wrap");
    tick();
    drive(8'h00, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
    ra_addr_3 = 3'd1;
    rb_addr_3 = 3'd2;
    #1;
    total++;
    if (ra_data_16 !== 16'hFF80) begin
      bad++;
      $display("FAIL sel_imm_r1: got %h want ff80", ra_data_16);
    end
    total++;
    if (rb_data_16 !== 16'h0000) begin
      bad++;
      $display("FAIL sel_pc_r2: got %h want 0000", rb_data_16);
    end
  endtask

  task automatic test_use_k();
    drive(8'h91, 3'd2, 3'd5, 16'h1234, 16'h0, 16'h0);
    ra_addr_3 = 3'd5;
    rb_addr_3 = 3'd2;
    check_comb("use_k");
    tick();
    drive(8'hE1, 3'd4, 3'd0, 16'h7777, 16'h0, 16'h0);
    ra_addr_3 = 3'd4;
    check_comb("sel_none");
    total++;
    if (wb_we !== 1'b0) begin
      bad++;
      $display("FAIL sel_none_we: got %b want 0", wb_we);
    end
    tick();
    check_all_regs("after_use_k");
  endtask

  task automatic test_redirect();
    drive(8'h81, 3'd7, 3'd0, 16'h0040, 16'h0, 16'h0);
    check_comb("r7_write");
    tick();
    drive(8'h00, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
    tick();
    drive(8'h81, 3'd7, 3'd0, 16'h0040, 16'h0, 16'h0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    drive(8'h00, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
    ra_addr_3 = 3'd7;
    #1;
    total++;
    if (ra_data_16 !== 16'h0000) begin
      bad++;
      $display("FAIL clr_r7: got %h want 0000", ra_data_16);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] tgt [3];
    for (int i = 0; i < 3; i++) tgt[i] = 16'($urandom_range(0, 16'hFFFF));
    for (int i = 0; i < 3; i++) begin
      drive(8'h81, 3'd7, 3'd0, tgt[i], 16'h0, 16'h0);
      ra_addr_3 = 3'd7;
      rb_addr_3 = 3'd0;
      check_comb("b2b");
      tick();
    end
    drive(8'h00, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
    tick();
    total++;
    if (redirect_pc_16 !== tgt[2]) begin
      bad++;
      $display("FAIL b2b_hold: got %h want %h", redirect_pc_16, tgt[2]);
    end
  endtask

  task automatic test_random();
    logic [7:0] cw;
    for (int n = 0; n < 300; n++) begin
      cw = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) cw[0] = 1'b1;
      drive(cw, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            16'($urandom_range(0, 16'hFFFF)),
            ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 16'hFFFF)),
            16'($urandom_range(0, 16'hFFFF)));
      ra_addr_3 = 3'($urandom_range(0, 7));
      rb_addr_3 = ($urandom_range(0, 3) == 0) ? ra_addr_3 : 3'($urandom_range(0, 7));
      clr = ($urandom_range(0, 39) == 0);
      check_comb("random");
      tick();
      clr = 1'b0;
    end
    check_all_regs("random_final");
  endtask

  task automatic test_retire();
    clr = 1'b1;
    drive(8'h00, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
    tick();
    clr = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (i == 2 || i == 6 || i == 10) drive(8'h00, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
      else drive(8'h01, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
      tick();
    end
`ifdef WB_RETIRE_CNT_EN
    total++;
    if (retired_cnt_16 !== 16'h000A) begin
      bad++;
      $display("FAIL retire_ten: got %h want 000a", retired_cnt_16);
    end
    drive(8'h01, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
    repeat (16'hFFF5) @(posedge clk);
    model_cnt = 16'hFFFF;
    #1;
    total++;
    if (retired_cnt_16 !== 16'hFFFF) begin
      bad++;
      $display("FAIL retire_full: got %h want ffff", retired_cnt_16);
    end
    tick();
    total++;
    if (retired_cnt_16 !== 16'h0000) begin
      bad++;
      $display("FAIL retire_wrap: got %h want 0000", retired_cnt_16);
    end
`else
    total++;
    if (retired_cnt_16 !== 16'h0000) begin
      bad++;
      $display("FAIL retire_absent: got %h want 0000", retired_cnt_16);
    end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 8; i++) model_rf[i] = 16'h0000;
    model_redirect_valid = 1'b0;
    model_redirect_pc    = 16'h0000;
    model_cnt            = 16'h0000;
    clr       = 1'b1;
    ra_addr_3 = 3'd0;
    rb_addr_3 = 3'd0;
    drive(8'h00, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
    @(posedge clk);
    #1;

    test_reset();
    test_bypass();
    test_wb_sel();
    test_use_k();
    test_redirect();
    test_back_to_back();
    test_random();
    test_retire();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
